// File: rtl/ram_wr_serializer_if.sv
// ram_wr_serializer_if
//   Bundles the request side (write strobes from the stimulus generator), the
//   narrow RAM write port and the status/counter outputs of ram_wr_serializer.
//   master : drives requests and i_ram_ready, observes everything else.
//   slave  : the serializer itself.
//   Signals:
//     i_wbit, i_address[ADDR_W], i_data[64], i_byteen[8]   request strobe/payload
//     o_full, o_overflow                                   FIFO status (overflow sticky)
//     o_ram_we, o_ram_addr[ADDR_W+2], o_ram_wdata[16],
//     o_ram_be[2], i_ram_ready                             RAM beat handshake
//     o_busy, o_beat_count[16], o_word_count[ADDR_W+1]     activity / counters
interface ram_wr_serializer_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              i_wbit;
  logic [ADDR_W-1:0] i_address;
  logic [63:0]       i_data;
  logic [7:0]        i_byteen;
  logic              o_full;
  logic              o_overflow;
  logic              o_ram_we;
  logic [ADDR_W+1:0] o_ram_addr;
  logic [15:0]       o_ram_wdata;
  logic [1:0]        o_ram_be;
  logic              i_ram_ready;
  logic              o_busy;
  logic [15:0]       o_beat_count;
  logic [ADDR_W:0]   o_word_count;

  modport master (
    output i_wbit, i_address, i_data, i_byteen, i_ram_ready,
    input  o_full, o_overflow, o_ram_we, o_ram_addr, o_ram_wdata, o_ram_be,
           o_busy, o_beat_count, o_word_count
  );

  modport slave (
    input  i_wbit, i_address, i_data, i_byteen, i_ram_ready,
    output o_full, o_overflow, o_ram_we, o_ram_addr, o_ram_wdata, o_ram_be,
           o_busy, o_beat_count, o_word_count
  );
endinterface

// File: rtl/ram_wr_serializer.sv
// ram_wr_serializer
//   Buffers 64-bit write requests in a FIFO_DEPTH-entry FIFO and serializes
//   each word into four 16-bit beats on a narrow RAM write port with a ready
//   handshake. Beat k carries i_data[16k+15:16k], i_byteen[2k+1:2k] and
//   address {i_address, k}. A strobe arriving while full is dropped and sets
//   the sticky overflow flag.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  synchronous active-low reset
//     bus      ram_wr_serializer_if.slave (request, RAM port, status, counters)
module ram_wr_serializer #(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  ram_wr_serializer_if.slave    bus
);
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENTRY_W = ADDR_W + 64 + 8;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]      count_q;
  logic                overflow_q;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [63:0]         hold_data_q, hold_data_d;
  logic [7:0]          hold_be_q, hold_be_d;
  logic [1:0]          beat_q, beat_d;
  logic                we_q, we_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic [1:0]          be_q, be_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                full, push, pop, accept;
  logic [ENTRY_W-1:0]  head;
  logic [ADDR_W-1:0]   head_addr;
  logic [63:0]         head_data;
  logic [7:0]          head_be;
  logic [1:0]          next_beat;

  function automatic logic [15:0] sel_data(input logic [63:0] d, input logic [1:0] b);
    case (b)
      2'd0:    sel_data = d[15:0];
      2'd1:    sel_data = d[31:16];
      2'd2:    sel_data = d[47:32];
      default: sel_data = d[63:48];
    endcase
  endfunction

  function automatic logic [1:0] sel_be(input logic [7:0] e, input logic [1:0] b);
    case (b)
      2'd0:    sel_be = e[1:0];
      2'd1:    sel_be = e[3:2];
      2'd2:    sel_be = e[5:4];
      default: sel_be = e[7:6];
    endcase
  endfunction

  // o_full comes straight from the registered count, so a same-cycle pop
  // never makes room for a push.
  assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push      = bus.i_wbit & ~full;
  assign accept    = we_q & bus.i_ram_ready;
  assign head      = mem_q[rd_ptr_q];
  assign head_addr = head[ENTRY_W-1:72];
  assign head_data = head[71:8];
  assign head_be   = head[7:0];
  assign next_beat = beat_q + 2'd1;

  // The output registers are loaded one cycle after the pop (the "prime"
  // cycle with we_q=0 in ISSUE); afterwards each acceptance loads the next
  // beat directly, and beat 3 chains straight into the FIFO head.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    hold_be_d   = hold_be_q;
    beat_d      = beat_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    beat_cnt_d  = beat_cnt_q;
    word_cnt_d  = word_cnt_q;
    case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (count_q != '0) begin
          pop         = 1'b1;
          hold_addr_d = head_addr;
          hold_data_d = head_data;
          hold_be_d   = head_be;
          beat_d      = 2'd0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!we_q) begin
          we_d    = 1'b1;
          addr_d  = {hold_addr_q, beat_q};
          wdata_d = sel_data(hold_data_q, beat_q);
          be_d    = sel_be(hold_be_q, beat_q);
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 16'd1;
          if (beat_q != 2'd3) begin
            beat_d  = next_beat;
            addr_d  = {hold_addr_q, next_beat};
            wdata_d = sel_data(hold_data_q, next_beat);
            be_d    = sel_be(hold_be_q, next_beat);
          end else begin
            word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
            if (count_q != '0) begin
              pop         = 1'b1;
              hold_addr_d = head_addr;
              hold_data_d = head_data;
              hold_be_d   = head_be;
              beat_d      = 2'd0;
              addr_d      = {head_addr, 2'd0};
              wdata_d     = head_data[15:0];
              be_d        = head_be[1:0];
            end else begin
              we_d    = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.i_address, bus.i_data, bus.i_byteen};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      hold_be_q   <= '0;
      beat_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      beat_cnt_q  <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      hold_be_q   <= hold_be_d;
      beat_q      <= beat_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      beat_cnt_q  <= beat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      overflow_q  <= overflow_q | (bus.i_wbit & full);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.o_full       = full;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_ram_we     = we_q;
  assign bus.o_ram_addr   = addr_q;
  assign bus.o_ram_wdata  = wdata_q;
  assign bus.o_ram_be     = be_q;
  assign bus.o_busy       = (count_q != '0) | (state_q != IDLE);
  assign bus.o_beat_count = beat_cnt_q;
  assign bus.o_word_count = word_cnt_q;
endmodule

// File: tb/tb_ram_wr_serializer.sv
module tb_ram_wr_serializer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // {ram_addr[15:0], wdata[15:0], be[1:0]}
  logic [33:0] exp_q [$];
  logic [33:0] obs_q [$];

  ram_wr_serializer_if #(.ADDR_W(14)) bus ();

  ram_wr_serializer #(.ADDR_W(14), .FIFO_DEPTH(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A beat shown at the falling edge with ready high is taken at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.o_ram_we && bus.i_ram_ready)
      obs_q.push_back({bus.o_ram_addr, bus.o_ram_wdata, bus.o_ram_be});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_data(input int unsigned a);
    logic [15:0] b;
    b = 16'(a * 4);
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic drive(input logic [13:0] a, input logic [63:0] d, input logic [7:0] e);
    bus.i_wbit    = 1'b1;
    bus.i_address = a;
    bus.i_data    = d;
    bus.i_byteen  = e;
  endtask

  task automatic push_word(input logic [13:0] a, input logic [63:0] d, input logic [7:0] e);
    for (int unsigned k = 0; k < 4; k++)
      exp_q.push_back({a, 2'(k), d[16*k +: 16], e[2*k +: 2]});
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.i_wbit      = 1'b0;
    bus.i_ram_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic wait_idle(input int unsigned max, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < max; i++) begin
      if (!bus.o_busy && !bus.o_ram_we) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.i_wbit      = 1'b1;
    bus.i_address   = 14'h5;
    bus.i_data      = 64'h1234;
    bus.i_byteen    = 8'hFF;
    bus.i_ram_ready = 1'b1;
    tick();
    tick();
    bus.i_wbit = 1'b0;
    tick();
    checks++;
    if ({bus.o_ram_we, bus.o_ram_addr, bus.o_ram_wdata, bus.o_ram_be} !== 35'd0) begin
      errors++;
      $display("FAIL reset_ram_port got %h want 0", {bus.o_ram_we, bus.o_ram_addr, bus.o_ram_wdata, bus.o_ram_be});
    end
    checks++;
    if ({bus.o_full, bus.o_overflow, bus.o_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status got %b want 000", {bus.o_full, bus.o_overflow, bus.o_busy});
    end
    checks++;
    if (bus.o_beat_count !== 16'd0 || bus.o_word_count !== 15'd0) begin
      errors++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", bus.o_beat_count, bus.o_word_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [33:0] e, o;
    bit ok;
    do_reset();
    drive(14'd1, {16'd7, 16'd6, 16'd5, 16'd4}, 8'hFF);
    push_word(14'd1, {16'd7, 16'd6, 16'd5, 16'd4}, 8'hFF);
    tick();
    bus.i_wbit = 1'b0;
    checks++;
    if (bus.o_ram_we !== 1'b0) begin
      errors++; $display("FAIL basic_lat_n0 got we=%b want 0", bus.o_ram_we);
    end
    tick();
    checks++;
    if (bus.o_ram_we !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++; $display("FAIL basic_lat_n1 got we=%b busy=%b want we=0 busy=1", bus.o_ram_we, bus.o_busy);
    end
    tick();
    checks++;
    if (bus.o_ram_we !== 1'b1 || bus.o_ram_addr !== 16'h0004) begin
      errors++; $display("FAIL basic_lat_n2 got we=%b addr=%h want we=1 addr=0004", bus.o_ram_we, bus.o_ram_addr);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_timeout got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL basic_beat got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL basic_beat got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (bus.o_beat_count !== 16'd4 || bus.o_word_count !== 15'd1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_counters got beats=%0d words=%0d busy=%b want 4/1/0", bus.o_beat_count, bus.o_word_count, bus.o_busy);
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] e, o;
    bit ok, found;
    do_reset();
    drive(14'd1, {16'd7, 16'd6, 16'd5, 16'd4}, 8'hFF);
    push_word(14'd1, {16'd7, 16'd6, 16'd5, 16'd4}, 8'hFF);
    tick();
    bus.i_wbit = 1'b0;
    found = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      if (bus.o_ram_we && bus.o_ram_addr == 16'h0005) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL bp_reach_beat1 got timeout want addr 0005"); end
    bus.i_ram_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.o_ram_we !== 1'b1 || bus.o_ram_addr !== 16'h0005 || bus.o_ram_wdata !== 16'd5) begin
        errors++;
        $display("FAIL bp_hold got we=%b addr=%h wdata=%h want 1/0005/0005", bus.o_ram_we, bus.o_ram_addr, bus.o_ram_wdata);
      end
    end
    bus.i_ram_ready = 1'b1;
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL bp_beat got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL bp_beat got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL bp_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (bus.o_beat_count !== 16'd4) begin errors++; $display("FAIL bp_beats got %0d want 4", bus.o_beat_count); end
  endtask

  task automatic test_overflow();
    logic [33:0] e, o;
    bit ok;
    do_reset();
    bus.i_ram_ready = 1'b0;
    for (int unsigned a = 1; a <= 6; a++) begin
      drive(14'(a), mk_data(a), 8'hFF);
      // The first entry pops into the holding register right away, so five fit.
      if (a <= 5) push_word(14'(a), mk_data(a), 8'hFF);
      tick();
      if (a == 5) begin
        checks++;
        if (bus.o_full !== 1'b1 || bus.o_overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_after5 got full=%b ovf=%b want 1/0", bus.o_full, bus.o_overflow);
        end
      end
      if (a == 6) begin
        checks++;
        if (bus.o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_after6 got %b want 1", bus.o_overflow); end
      end
    end
    bus.i_wbit      = 1'b0;
    bus.i_ram_ready = 1'b1;
    wait_idle(60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_timeout got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL ovf_beat got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL ovf_beat got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL ovf_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (bus.o_word_count !== 15'd5 || bus.o_beat_count !== 16'd20 || bus.o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_counters got words=%0d beats=%0d ovf=%b want 5/20/1", bus.o_word_count, bus.o_beat_count, bus.o_overflow);
    end
  endtask

  task automatic test_wrap();
    logic [33:0] e, o;
    bit ok;
    do_reset();
    drive(14'h3FFF, 64'h1111_2222_3333_4444, 8'h5A);
    tick();
    bus.i_wbit = 1'b0;
    exp_q.push_back({16'hFFFC, 16'h4444, 2'b10});
    exp_q.push_back({16'hFFFD, 16'h3333, 2'b10});
    exp_q.push_back({16'hFFFE, 16'h2222, 2'b01});
    exp_q.push_back({16'hFFFF, 16'h1111, 2'b01});
    wait_idle(20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wrap_timeout got busy want idle"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wrap_beat got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL wrap_beat got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] e, o;
    int unsigned n, total, runs;
    bit prev_we;
    n = 0; total = 0; runs = 0; prev_we = 1'b0;
    do_reset();
    // One word every 3 cycles keeps ahead of the 4-cycle drain without
    // overrunning the 4-deep FIFO across 8 words.
    for (int unsigned cyc = 0; cyc < 80; cyc++) begin
      if (cyc % 3 == 0 && n < 8) begin
        n++;
        drive(14'(n), mk_data(n), 8'hFF);
        push_word(14'(n), mk_data(n), 8'hFF);
      end else begin
        bus.i_wbit = 1'b0;
      end
      tick();
      if (bus.o_ram_we) begin
        total++;
        if (!prev_we) runs++;
      end
      prev_we = bus.o_ram_we;
    end
    checks++;
    if (total != 32 || runs != 1) begin
      errors++; $display("FAIL b2b_contiguous got beats=%0d runs=%0d want 32/1", total, runs);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL b2b_beat got none want %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin errors++; $display("FAIL b2b_beat got %h want %h", o, e); end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d want 0", obs_q.size()); obs_q.delete(); end
    checks++;
    if (bus.o_beat_count !== 16'd32 || bus.o_word_count !== 15'd8 || bus.o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_counters got beats=%0d words=%0d ovf=%b want 32/8/0", bus.o_beat_count, bus.o_word_count, bus.o_overflow);
    end
  endtask

  task automatic test_reset_mid();
    bit found, ok;
    int unsigned stale;
    do_reset();
    for (int unsigned a = 10; a <= 12; a++) begin
      drive(14'(a), mk_data(a), 8'hFF);
      tick();
    end
    bus.i_wbit = 1'b0;
    found = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (bus.o_ram_we && bus.o_ram_addr == {14'd10, 2'd2}) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmid_reach_beat2 got timeout want addr %h", {14'd10, 2'd2}); end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.o_ram_we, bus.o_busy, bus.o_full} !== 3'b000) begin
      errors++; $display("FAIL rmid_status got we/busy/full=%b want 000", {bus.o_ram_we, bus.o_busy, bus.o_full});
    end
    checks++;
    if (bus.o_beat_count !== 16'd0 || bus.o_word_count !== 15'd0) begin
      errors++; $display("FAIL rmid_counters got %0d/%0d want 0/0", bus.o_beat_count, bus.o_word_count);
    end
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
    stale = 0;
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      if (bus.o_ram_we || bus.o_busy) stale++;
    end
    checks++;
    if (stale != 0 || obs_q.size() != 0) begin
      errors++; $display("FAIL rmid_stale got active=%0d beats=%0d want 0/0", stale, obs_q.size());
    end
    drive(14'd2, mk_data(2), 8'hFF);
    tick();
    bus.i_wbit = 1'b0;
    tick();
    wait_idle(20, ok);
    checks++;
    if (!ok || bus.o_word_count !== 15'd1 || obs_q.size() != 4) begin
      errors++; $display("FAIL rmid_recover got ok=%b words=%0d beats=%0d want 1/1/4", ok, bus.o_word_count, obs_q.size());
    end
    obs_q.delete();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.i_wbit      = 1'b0;
    bus.i_address   = '0;
    bus.i_data      = '0;
    bus.i_byteen    = '0;
    bus.i_ram_ready = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "simulation time limit");
  end
endmodule
